dsp_opcode_seq: RTL and testbench

DSP_OPCODE_SEQ -- requirements
Module: dsp_opcode_seq

---
 rtl/dsp_pkg.sv | 61 ++++++
 rtl/dsp_term_cnt.sv | 39 +++
 rtl/dsp_opcode_seq.sv | 159 +++++++++++++++
 tb/tb_dsp_opcode_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// ----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the DSP opcode sequencer:
//   xsel_e  - X-mux select encoding (OPCODE_01)
//   zsel_e  - Z-mux select encoding (OPCODE_23)
//   op_e    - command opcode encoding (cmd_op)
//   state_e - sequencer FSM states
//   issue_zsel() - Z-mux select for one issued term of a command
// ----------------------------------------------------------------------------
package dsp_pkg;

    typedef enum logic [1:0] {
        XSEL_ZERO  = 2'd0,
        XSEL_PROD  = 2'd1,
        XSEL_PCOUT = 2'd2,
        XSEL_DAB   = 2'd3
    } xsel_e;

    typedef enum logic [1:0] {
        ZSEL_ZERO  = 2'd0,
        ZSEL_PCIN  = 2'd1,
        ZSEL_PCOUT = 2'd2,
        ZSEL_C     = 2'd3
    } zsel_e;

    typedef enum logic [1:0] {
        OP_MAC   = 2'd0,
        OP_MUL   = 2'd1,
        OP_CASC  = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // First term seeds the accumulator (zero, C or PCIN); later terms
    // accumulate onto PCOUT. MUL never accumulates.
    function automatic zsel_e issue_zsel(input op_e op, input logic first,
                                         input logic use_c);
        zsel_e z;
        z = ZSEL_ZERO;
        case (op)
            OP_MAC: begin
                if (!first)     z = ZSEL_PCOUT;
                else if (use_c) z = ZSEL_C;
                else            z = ZSEL_ZERO;
            end
            OP_CASC: begin
                if (first) z = ZSEL_PCIN;
                else       z = ZSEL_PCOUT;
            end
            default: z = ZSEL_ZERO;
        endcase
        return z;
    endfunction

endpackage

// File: rtl/dsp_term_cnt.sv
// ----------------------------------------------------------------------------
// dsp_term_cnt
// Term counter for the opcode sequencer.
//   clk_i   - clock
//   rst_n_i - asynchronous active-low reset (count -> 0)
//   load_i  - clear count to 0 (has priority over en_i)
//   en_i    - increment count
//   last_i  - index of the final term (N-1)
//   cnt_o   - current term index
//   tc_o    - terminal count: cnt_o == last_i
// ----------------------------------------------------------------------------
module dsp_term_cnt #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [LEN_W-1:0] last_i,
    output logic [LEN_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [LEN_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + LEN_W'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/dsp_opcode_seq.sv
// ----------------------------------------------------------------------------
// dsp_opcode_seq
// Sequences DSP-slice X/Z mux opcodes and multiplier enable for MAC, MUL,
// CASC and CLEAR commands of N terms.
//   CLK, RST_N          - clock, asynchronous active-low reset
//   abort               - (only with `OPSEQ_ABORT_EN) cancel current command
//   cmd_valid/cmd_ready - command handshake; ready only in IDLE
//   cmd_op/cmd_len      - opcode and term count N
//   cmd_use_c           - MAC: seed accumulator from C
//   OPCODE_01/OPCODE_23 - X / Z mux selects
//   CE_M                - multiplier clock enable
//   busy                - sequencer not idle
//   p_valid, done       - P holds a result / command complete pulse
//   term_cnt            - index of the term being issued
// Build option: define OPSEQ_ABORT_EN to add the abort input.
// ----------------------------------------------------------------------------
module dsp_opcode_seq
    import dsp_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned LEN_W   = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
`ifdef OPSEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_use_c,
    output logic [1:0]       OPCODE_01,
    output logic [1:0]       OPCODE_23,
    output logic             CE_M,
    output logic             busy,
    output logic             p_valid,
    output logic             done,
    output logic [LEN_W-1:0] term_cnt
);

    state_e           state_q;
    op_e              op_q;
    logic [LEN_W-1:0] len_q;
    logic             use_c_q;
    logic [1:0]       prime_q;
    xsel_e            x_q;
    zsel_e            z_q;
    logic             ce_q;
    logic             pv_q;
    logic             done_q;

    logic             accept;
    logic             kill;
    logic             cnt_en;
    logic             cnt_tc;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;

`ifdef OPSEQ_ABORT_EN
    assign kill = abort && (state_q != ST_IDLE);
`else
    assign kill = 1'b0;
`endif

    // Counter clears on accept so PRIME shows 0; it stops on the last term
    // so term_cnt holds N-1 through DRAIN and IDLE.
    assign cnt_en = (state_q == ST_ISSUE) && !cnt_tc && !kill;

    dsp_term_cnt #(
        .LEN_W (LEN_W)
    ) u_term_cnt (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .load_i  (accept),
        .en_i    (cnt_en),
        .last_i  (len_q - LEN_W'(1)),
        .cnt_o   (term_cnt),
        .tc_o    (cnt_tc)
    );

    // Outputs are registered for the state being entered; abort gates them
    // combinationally so the cancelled cycle is already quiet.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MAC;
            len_q   <= '0;
            use_c_q <= 1'b0;
            prime_q <= '0;
            x_q     <= XSEL_ZERO;
            z_q     <= ZSEL_ZERO;
            ce_q    <= 1'b0;
            pv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            x_q    <= XSEL_ZERO;
            z_q    <= ZSEL_ZERO;
            ce_q   <= 1'b0;
            pv_q   <= 1'b0;
            done_q <= 1'b0;
            if (kill) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            op_q    <= op_e'(cmd_op);
                            len_q   <= cmd_len;
                            use_c_q <= cmd_use_c;
                            prime_q <= '0;
                            if (op_e'(cmd_op) == OP_CLEAR || cmd_len == '0) begin
                                state_q <= ST_DRAIN;
                                pv_q    <= 1'b1;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_PRIME;
                                ce_q    <= 1'b1;
                            end
                        end
                    end
                    ST_PRIME: begin
                        ce_q <= 1'b1;
                        if (prime_q == 2'(MUL_LAT - 1)) begin
                            state_q <= ST_ISSUE;
                            x_q     <= XSEL_PROD;
                            z_q     <= issue_zsel(op_q, 1'b1, use_c_q);
                        end else begin
                            prime_q <= prime_q + 2'd1;
                        end
                    end
                    ST_ISSUE: begin
                        if (cnt_tc) begin
                            state_q <= ST_DRAIN;
                            pv_q    <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            ce_q <= 1'b1;
                            x_q  <= XSEL_PROD;
                            z_q  <= issue_zsel(op_q, 1'b0, use_c_q);
                            pv_q <= (op_q == OP_MUL);
                        end
                    end
                    ST_DRAIN: state_q <= ST_IDLE;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign OPCODE_01 = kill ? 2'b00 : x_q;
    assign OPCODE_23 = kill ? 2'b00 : z_q;
    assign CE_M      = ce_q && !kill;
    assign p_valid   = pv_q && !kill;
    assign done      = done_q && !kill;

endmodule

// File: tb/tb_dsp_opcode_seq.sv
// ----------------------------------------------------------------------------
// tb_dsp_opcode_seq
// Self-checking bench for dsp_opcode_seq. A reference model expands each
// accepted command into the per-cycle output trace it must produce; every
// cycle the DUT outputs are compared against the head of that trace.
// Define OPSEQ_ABORT_EN to also exercise the abort input.
// ----------------------------------------------------------------------------
module tb_dsp_opcode_seq;

    localparam int unsigned MUL_LAT = 1;
    localparam int unsigned LEN_W   = 4;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_use_c;
    logic [1:0]       OPCODE_01;
    logic [1:0]       OPCODE_23;
    logic             CE_M;
    logic             busy;
    logic             p_valid;
    logic             done;
    logic [LEN_W-1:0] term_cnt;
`ifdef OPSEQ_ABORT_EN
    logic             abort;
`endif

    always #5 CLK = ~CLK;

    dsp_opcode_seq #(
        .MUL_LAT (MUL_LAT),
        .LEN_W   (LEN_W)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
`ifdef OPSEQ_ABORT_EN
        .abort     (abort),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_use_c (cmd_use_c),
        .OPCODE_01 (OPCODE_01),
        .OPCODE_23 (OPCODE_23),
        .CE_M      (CE_M),
        .busy      (busy),
        .p_valid   (p_valid),
        .done      (done),
        .term_cnt  (term_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for one clock cycle.
    typedef struct packed {
        logic [1:0]       x;
        logic [1:0]       z;
        logic             ce;
        logic             pv;
        logic             dn;
        logic             bz;
        logic [LEN_W-1:0] tc;
    } rec_t;

    typedef struct {
        int op;
        int len;
        bit usec;
    } cmd_t;

    rec_t q[$];
    cmd_t dir_q[$];
    rec_t cur;
    int   last_tc;
    bit   pend;
    cmd_t pcmd;
    bit   rnd_mode;
    bit   found;

    function automatic rec_t mk(int x, int z, int ce, int pv, int dn, int bz, int tc);
        rec_t r;
        r.x  = 2'(x);
        r.z  = 2'(z);
        r.ce = 1'(ce);
        r.pv = 1'(pv);
        r.dn = 1'(dn);
        r.bz = 1'(bz);
        r.tc = LEN_W'(tc);
        return r;
    endfunction

    // Expand a command into the cycles following its accept edge.
    task automatic push_cmd(input cmd_t c);
        if (c.op == 3 || c.len == 0) begin
            q.push_back(mk(0, 0, 0, 1, 1, 1, 0));
            last_tc = 0;
        end else begin
            for (int i = 0; i < int'(MUL_LAT); i++) q.push_back(mk(0, 0, 1, 0, 0, 1, 0));
            for (int k = 0; k < c.len; k++) begin
                int z;
                case (c.op)
                    0:       z = (k == 0) ? (c.usec ? 3 : 0) : 2;
                    1:       z = 0;
                    default: z = (k == 0) ? 1 : 2;
                endcase
                q.push_back(mk(1, z, 1, (c.op == 1 && k > 0) ? 1 : 0, 0, 1, k));
            end
            q.push_back(mk(0, 0, 0, 1, 1, 1, c.len - 1));
            last_tc = c.len - 1;
        end
    endtask

    task automatic check_cur(input rec_t e);
        chk("opcode_01", 32'(OPCODE_01), 32'(e.x));
        chk("opcode_23", 32'(OPCODE_23), 32'(e.z));
        chk("ce_m",      32'(CE_M),      32'(e.ce));
        chk("p_valid",   32'(p_valid),   32'(e.pv));
        chk("done",      32'(done),      32'(e.dn));
        chk("busy",      32'(busy),      32'(e.bz));
        chk("cmd_ready", 32'(cmd_ready), 32'(!e.bz));
        chk("term_cnt",  32'(term_cnt),  32'(e.tc));
    endtask

    // Producer: holds a command on the interface until the sequencer is idle.
    task automatic drive(input bit idle);
        if (!pend) begin
            if (dir_q.size() > 0) begin
                pcmd = dir_q.pop_front();
                pend = 1'b1;
            end else if (rnd_mode && $urandom_range(0, 2) == 0) begin
                pcmd.op   = int'($urandom_range(0, 3));
                pcmd.len  = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 5));
                pcmd.usec = 1'($urandom_range(0, 1));
                pend      = 1'b1;
            end
        end
        cmd_valid = pend;
        if (pend) begin
            cmd_op    = 2'(pcmd.op);
            cmd_len   = LEN_W'(pcmd.len);
            cmd_use_c = pcmd.usec;
        end else begin
            cmd_op    = 2'($urandom);
            cmd_len   = LEN_W'($urandom);
            cmd_use_c = 1'($urandom);
        end
        if (pend && idle) begin
            push_cmd(pcmd);
            pend = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge CLK);
        cur = (q.size() > 0) ? q.pop_front() : mk(0, 0, 0, 0, 0, 0, last_tc);
        check_cur(cur);
        drive(!cur.bz);
    endtask

    initial begin
        pend      = 1'b0;
        rnd_mode  = 1'b0;
        last_tc   = 0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_len   = '0;
        cmd_use_c = 1'b0;
`ifdef OPSEQ_ABORT_EN
        abort     = 1'b0;
`endif

        repeat (3) @(posedge CLK);
        #1 check_cur(mk(0, 0, 0, 0, 0, 0, 0));

        // Directed commands, queued back to back so later ones wait on busy.
        dir_q.push_back('{0, 3, 1'b0});
        dir_q.push_back('{1, 4, 1'b0});
        dir_q.push_back('{3, 5, 1'b1});
        dir_q.push_back('{0, 0, 1'b1});
        dir_q.push_back('{2, 2, 1'b1});
        dir_q.push_back('{0, 15, 1'b1});
        dir_q.push_back('{1, 1, 1'b0});

        // Command offered on the first edge after reset release.
        @(negedge CLK);
        RST_N = 1'b1;
        drive(1'b1);
        repeat (70) step();

        rnd_mode = 1'b1;
        repeat (500) step();
        rnd_mode = 1'b0;
        repeat (40) step();

        // Reset during ISSUE term 2 of MAC N=5.
        dir_q.push_back('{0, 5, 1'b0});
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (cur.ce && cur.x == 2'd1 && cur.tc == LEN_W'(2)) found = 1'b1;
        end
        chk("reset_window", 32'(found), 32'd1);
        #2 RST_N = 1'b0;
        #1 check_cur(mk(0, 0, 0, 0, 0, 0, 0));
        q.delete();
        last_tc = 0;
        pend    = 1'b0;
        cmd_valid = 1'b0;
        @(posedge CLK);
        #1 check_cur(mk(0, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        RST_N = 1'b1;
        dir_q.push_back('{0, 2, 1'b1});
        drive(1'b1);
        repeat (8) step();

`ifdef OPSEQ_ABORT_EN
        // Abort during ISSUE of MUL N=8.
        dir_q.push_back('{1, 8, 1'b0});
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (cur.ce && cur.x == 2'd1 && cur.tc == LEN_W'(3)) found = 1'b1;
        end
        chk("abort_window", 32'(found), 32'd1);
        abort = 1'b1;
        #1;
        chk("abort_opcode_01", 32'(OPCODE_01), 32'd0);
        chk("abort_opcode_23", 32'(OPCODE_23), 32'd0);
        chk("abort_ce_m",      32'(CE_M),      32'd0);
        chk("abort_p_valid",   32'(p_valid),   32'd0);
        chk("abort_done",      32'(done),      32'd0);
        chk("abort_busy",      32'(busy),      32'd1);
        q.delete();
        last_tc = 3;
        @(posedge CLK);
        #1 abort = 1'b0;
        // Abort while idle must not block a simultaneous accept.
        dir_q.push_back('{0, 1, 1'b0});
        step();
        abort = 1'b1;
        @(posedge CLK);
        #1 abort = 1'b0;
        repeat (6) step();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
